dnoc_pingpong_sched: RTL
========================

// Module: dnoc_pingpong_sched
// PURPOSE
//  Ping-pong buffer scheduler for the L2 core-write path. Drives dnoc_itf_core_wr's command request, tracks
//  which L2 ping/pong buffer is full (pingpong_state), and hands full buffers one at a time to a downstream
//  reader engine (req/gnt/done). Signals completion once the writer has finished and every buffer is drained.
// PARAMETERS
//  NUM_W    11  width of cfg_pingpong_num (pairs of buffers)
//  CNT_W    12  width of written/read buffer counters
// PORTS
//  clk                   in   1      clock
//  rst                   in   1      asynchronous reset, active-high
//  sched_start           in   1      start pulse; ignored unless idle
//  cfg_pingpong_en       in   1      1: ping/pong alternation; 0: single buffer
//  sched_busy            out  1      high from accepted start until sched_done
//  sched_done            out  1      1-cycle completion pulse
//  wr_cmd_req            out  1      to core_cmd_core_wr_req
//  wr_cmd_gnt            in   1      from core_cmd_core_wr_gnt
//  wr_pingpong_done      in   1      from pingpong_wr_done (one buffer written)
//  wr_transaction_done   in   1      from c_w_transaction_done
//  pingpong_state        out  2      [0] ping full, [1] pong full; to writer
//  rd_req                out  1      full buffer available to reader
//  rd_buf_sel            out  1      0 ping, 1 pong; valid with rd_req and while reading
//  rd_gnt                in   1      reader accepts rd_req
//  rd_done               in   1      reader finished consuming rd_buf_sel
//  wr_buf_cnt            out  CNT_W  buffers marked full since start
//  rd_buf_cnt            out  CNT_W  buffers drained since start
//  sched_err             out  1      sticky protocol error (DNOC_PP_SCHED_ERR_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all outputs 0; main FSM IDLE, read FSM R_IDLE, wr_ptr=rd_ptr=0, counters 0. Reset mid-operation
//   discards all state immediately; no pulses are emitted afterwards.
//  Main FSM (all outputs registered):
//   IDLE : sched_start -> RUN; clears pingpong_state, ptrs, counters; sched_busy=1 next cycle.
//   RUN  : wr_cmd_req=1 (held across multiple gnts; writer self-gates with pingpong_state).
//          wr_transaction_done -> DRAIN, wr_cmd_req drops next cycle.
//   DRAIN: pingpong_state==0 and read FSM in R_IDLE -> DONE.
//   DONE : sched_done=1 for one cycle, sched_busy=0 -> IDLE.
//  Buffer marking (in RUN only):
//   cfg_pingpong_en=1: wr_pingpong_done sets pingpong_state[wr_ptr], toggles wr_ptr, wr_buf_cnt++.
//   cfg_pingpong_en=0: wr_transaction_done sets pingpong_state[0], wr_buf_cnt++; wr_pingpong_done ignored.
//   Marked bit visible the cycle after the done pulse (1-cycle latency).
//  Read FSM (active in RUN and DRAIN):
//   R_IDLE: pingpong_state[rd_ptr]=1 -> rd_req=1, rd_buf_sel=rd_ptr (combinational from registers).
//           rd_req & rd_gnt -> R_BUSY.
//   R_BUSY: rd_req=0, rd_buf_sel held; rd_done clears pingpong_state[rd_ptr], toggles rd_ptr
//           (only if cfg_pingpong_en), rd_buf_cnt++ -> R_IDLE.
//   Strict order: ping, pong, ping ... never skips; rd_ptr fixed at 0 in single-buffer mode.
//  Simultaneous events: set of one bit and clear of the other in the same cycle both apply. rd_done and
//   wr_pingpong_done on the same buffer in one cycle: clear then set -> bit ends 1 (buffer refilled).
//  Violations: wr_pingpong_done while pingpong_state[wr_ptr]=1 -> ignored (no set, no toggle, no count);
//   rd_done outside R_BUSY -> ignored. Counters wrap at 2^CNT_W silently.
//  wr_cmd_gnt is monitored only; it does not alter sequencing.
// CONFIGURATION
//  `DNOC_PP_SCHED_ERR_EN defined: sched_err set one cycle after either violation above, or
//   wr_transaction_done with cfg_pingpong_en=0 while pingpong_state[0]=1; cleared only by rst or sched_start.
//  Undefined: error logic removed, sched_err constant 0; violations still ignored as above.
// TESTING
//  1 pp_en=1, 2 pairs: writer pulses wr_pingpong_done x4, reader gnt 2 cycles later, done 5 cycles later ->
//    rd_buf_sel 0,1,0,1; wr_buf_cnt=rd_buf_cnt=4; sched_done 1 cycle after last clear + transaction_done.
//  2 pp_en=0: wr_transaction_done -> state=01, rd_req sel 0; rd_done -> DRAIN->DONE, sched_done pulse, cnt=1/1.
//  3 Reader stalled (rd_gnt=0): two wr_pingpong_done -> state=11, writer gated; third done -> ignored,
//    wr_buf_cnt stays 2; with ERR_EN sched_err=1, without sched_err=0.
//  4 Same-cycle rd_done (ping) and wr_pingpong_done (pong) with state=01 -> state=10, both counters ++.
//  5 rst asserted in RUN with state=11 and R_BUSY -> all outputs 0 same edge; sched_start 3 cycles later runs cleanly.
//  6 sched_start pulsed in RUN -> ignored, counters unchanged, no second sched_done.

Source files
------------

// File: rtl/dnoc_pingpong_sched.sv
// Ping-pong buffer scheduler for the L2 core-write path: drives the write command, tracks full buffers and
// hands them to a reader in strict ping/pong order. Optional sticky error flag under `DNOC_PP_SCHED_ERR_EN.
module dnoc_pingpong_sched #(
  parameter int NUM_W = 11,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_start,
  input  logic             cfg_pingpong_en,
  output logic             sched_busy,
  output logic             sched_done,
  output logic             wr_cmd_req,
  input  logic             wr_cmd_gnt,
  input  logic             wr_pingpong_done,
  input  logic             wr_transaction_done,
  output logic [1:0]       pingpong_state,
  output logic             rd_req,
  output logic             rd_buf_sel,
  input  logic             rd_gnt,
  input  logic             rd_done,
  output logic [CNT_W-1:0] wr_buf_cnt,
  output logic [CNT_W-1:0] rd_buf_cnt,
  output logic             sched_err
);

  if (NUM_W < 1 || CNT_W < 2) begin : g_param_check
    $error("dnoc_pingpong_sched: NUM_W must be >= 1 and CNT_W >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic {R_IDLE, R_BUSY} rstate_t;

  state_t  state;
  rstate_t rstate;
  logic    wr_ptr;
  logic    rd_ptr;

  logic       active;
  logic       rd_clr;
  logic       pp_mark;
  logic       sp_mark;
  logic       viol;
  logic [1:0] cleared;
  logic [1:0] pp_next;

  // The command grant is observed by the writer itself; sequencing never depends on it.
  logic gnt_unused;
  assign gnt_unused = wr_cmd_gnt;

  always_comb begin
    active  = (state == RUN) || (state == DRAIN);
    rd_req  = active && (rstate == R_IDLE) && pingpong_state[rd_ptr];
    rd_buf_sel = rd_ptr;
    rd_clr  = active && (rstate == R_BUSY) && rd_done;
    // Clear is applied before set, so a same-cycle drain and refill of one buffer leaves it full.
    cleared = pingpong_state;
    if (rd_clr) cleared[rd_ptr] = 1'b0;
    pp_mark = (state == RUN) && cfg_pingpong_en && wr_pingpong_done && !cleared[wr_ptr];
    sp_mark = (state == RUN) && !cfg_pingpong_en && wr_transaction_done;
    pp_next = cleared;
    if (pp_mark) pp_next[wr_ptr] = 1'b1;
    if (sp_mark) pp_next[0] = 1'b1;
    viol = ((state == RUN) && cfg_pingpong_en && wr_pingpong_done && cleared[wr_ptr])
        || ((state == RUN) && !cfg_pingpong_en && wr_transaction_done && cleared[0])
        || (rd_done && !(active && (rstate == R_BUSY)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rstate         <= R_IDLE;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      pingpong_state <= 2'b00;
      wr_buf_cnt     <= '0;
      rd_buf_cnt     <= '0;
      sched_busy     <= 1'b0;
      sched_done     <= 1'b0;
      wr_cmd_req     <= 1'b0;
    end else begin
      sched_done <= 1'b0;
      case (state)
        IDLE: if (sched_start) begin
          state          <= RUN;
          rstate         <= R_IDLE;
          wr_ptr         <= 1'b0;
          rd_ptr         <= 1'b0;
          pingpong_state <= 2'b00;
          wr_buf_cnt     <= '0;
          rd_buf_cnt     <= '0;
          sched_busy     <= 1'b1;
          wr_cmd_req     <= 1'b1;
        end
        RUN: if (wr_transaction_done) begin
          state      <= DRAIN;
          wr_cmd_req <= 1'b0;
        end
        DRAIN: if (pingpong_state == 2'b00 && rstate == R_IDLE) begin
          state      <= DONE;
          sched_done <= 1'b1;
          sched_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (active) begin
        pingpong_state <= pp_next;
        if (pp_mark) wr_ptr <= ~wr_ptr;
        if (pp_mark || sp_mark) wr_buf_cnt <= wr_buf_cnt + 1'b1;
        if (rd_req && rd_gnt) rstate <= R_BUSY;
        if (rd_clr) begin
          rstate     <= R_IDLE;
          rd_buf_cnt <= rd_buf_cnt + 1'b1;
          if (cfg_pingpong_en) rd_ptr <= ~rd_ptr;
        end
      end
    end
  end

`ifdef DNOC_PP_SCHED_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sched_err <= 1'b0;
    end else if (state == IDLE && sched_start) begin
      sched_err <= 1'b0;
    end else if (viol) begin
      sched_err <= 1'b1;
    end
  end
`else
  logic viol_unused;
  assign viol_unused = viol;
  assign sched_err   = 1'b0;
`endif

endmodule
